// File: rtl/speech_sequencer_if.sv
// Bus between the utterance driver / phoneme ROM and speech_sequencer.
// master: drives start, abort, address, rom_data; slave: the sequencer.
interface speech_sequencer_if;
    logic        start;
    logic        abort;
    logic [12:0] address;
    logic [7:0]  rom_data;
    logic [12:0] rom_addr;
    logic [4:0]  phoneme;
    logic        phoneme_valid;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, address, rom_data,
        input  rom_addr, phoneme, phoneme_valid, busy, done
    );

    modport slave (
        input  start, abort, address, rom_data,
        output rom_addr, phoneme, phoneme_valid, busy, done
    );
endinterface

// File: rtl/speech_sequencer.sv
// Walks the phoneme ROM from a start address, plays each phoneme for its
// encoded duration. Ports: clk, nrst (async low), bus (slave modport).
module speech_sequencer #(
    parameter int TICK_CYCLES = 256,
    parameter int MAX_LEN     = 64
) (
    input logic               clk,
    input logic               nrst,
    speech_sequencer_if.slave bus
);
    localparam int CW = $clog2(4 * TICK_CYCLES);
    localparam int NW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [12:0]     rom_addr_q, rom_addr_d;
    logic [4:0]      phoneme_q, phoneme_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   count_q, count_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            phoneme_q  <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            phoneme_q  <= phoneme_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        phoneme_d  = phoneme_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        count_d    = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    rom_addr_d = bus.address;
                    count_d    = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                phoneme_d = bus.rom_data[4:0];
                last_d    = bus.rom_data[7];
                // Play time (dur+1)*TICK_CYCLES, counted down to zero.
                cnt_d     = CW'((int'(bus.rom_data[6:5]) + 1)
                                * TICK_CYCLES - 1);
                count_d   = count_q + NW'(1);
                state_d   = S_PLAY;
            end
            S_PLAY: begin
                if (cnt_q == '0) begin
                    if (last_q || count_q == NW'(MAX_LEN)) begin
                        state_d = S_DONE;
                    end else begin
                        rom_addr_d = rom_addr_q + 13'd1;
                        state_d    = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel overrides every other transition.
        if (bus.abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            phoneme_d = '0;
        end
    end

    assign bus.rom_addr      = rom_addr_q;
    assign bus.phoneme       = phoneme_q;
    assign bus.phoneme_valid = (state_q == S_PLAY) && (phoneme_q != '0);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
endmodule

// File: tb/tb_speech_sequencer.sv
// Testbench for speech_sequencer: expected per-cycle traces from a ROM
// walk model, checked by an independent monitor.
module tb_speech_sequencer;
    localparam int TICK = 4;
    localparam int MAXL = 4;

    typedef struct {
        logic [12:0] addr;
        logic        valid;
        logic        done;
        logic        chkph;
        logic [4:0]  ph;
    } rec_t;

    logic clk;
    logic nrst;
    int   n_chk;
    int   n_fail;

    logic [7:0] mem [0:8191];
    rec_t       sb[$];
    rec_t       tr[$];

    speech_sequencer_if bus ();

    speech_sequencer #(
        .TICK_CYCLES(TICK),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle synchronous ROM
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    // Monitor: every busy cycle consumes one expected record.
    always @(negedge clk) begin
        rec_t r;
        if (nrst && (bus.busy || bus.done)) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_busy: busy=%b done=%b addr=%h, required idle",
                         bus.busy, bus.done, bus.rom_addr);
            end else begin
                r = sb.pop_front();
                if (bus.rom_addr !== r.addr || bus.phoneme_valid !== r.valid ||
                    bus.done !== r.done ||
                    (r.chkph && bus.phoneme !== r.ph)) begin
                    n_fail++;
                    $display("FAIL trace: addr=%h valid=%b done=%b ph=%0d, required addr=%h valid=%b done=%b ph=%0d(chk=%b)",
                             bus.rom_addr, bus.phoneme_valid, bus.done, bus.phoneme,
                             r.addr, r.valid, r.done, r.ph, r.chkph);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference: walk ROM bytes, expand each into its cycle trace.
    task automatic build(input logic [12:0] start_a);
        logic [12:0] a;
        logic [7:0]  b;
        int          n;
        rec_t        r;
        tr.delete();
        a = start_a;
        n = 0;
        while (1) begin
            b = mem[a];
            n++;
            r = '{addr: a, valid: 1'b0, done: 1'b0, chkph: 1'b0, ph: 5'd0};
            tr.push_back(r);
            tr.push_back(r);
            r.valid = (b[4:0] != 0);
            r.chkph = 1'b1;
            r.ph    = b[4:0];
            repeat ((int'(b[6:5]) + 1) * TICK) tr.push_back(r);
            if (b[7] || n == MAXL) begin
                r.valid = 1'b0;
                r.done  = 1'b1;
                tr.push_back(r);
                break;
            end
            a = a + 13'd1;
        end
    endtask

    task automatic run_utt(input logic [12:0] a, input int abort_at,
                           input int bs_at, input int rst_at);
        int n;
        bit aborted;
        bit was_rst;
        build(a);
        n = tr.size();
        aborted = (abort_at > 0 && abort_at < n);
        was_rst = 1'b0;
        if (aborted) n = abort_at;
        for (int i = 0; i < n; i++) sb.push_back(tr[i]);
        bus.start   = 1'b1;
        bus.address = a;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.address = 13'($urandom);
        for (int c = 1; c <= n; c++) begin
            bus.abort = (c == abort_at);
            bus.start = (c == bs_at);
            if (c == bs_at) bus.address = 13'h200;
            if (c == rst_at) begin
                nrst = 1'b0;
                #1;
                check("rst_busy", 32'(bus.busy), 0);
                check("rst_valid", 32'(bus.phoneme_valid), 0);
                check("rst_addr", 32'(bus.rom_addr), 0);
                check("rst_phoneme", 32'(bus.phoneme), 0);
                check("rst_done", 32'(bus.done), 0);
                sb.delete();
                bus.start = 1'b0;
                @(posedge clk); #1;
                nrst = 1'b1;
                was_rst = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (!was_rst) begin
            check("idle_after", 32'(bus.busy), 0);
            if (aborted) begin
                check("abort_phoneme", 32'(bus.phoneme), 0);
                repeat (10) @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        check("sb_drained", 32'(sb.size()), 0);
    endtask

    initial begin
        int len;
        int ab;
        int bs;
        logic [12:0] ra;
        n_chk  = 0;
        n_fail = 0;
        nrst   = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.address = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[13'h100] = 8'h25;
        mem[13'h101] = 8'h83;
        mem[13'h1FFF] = 8'h00;
        mem[13'h0000] = 8'h87;
        for (int i = 16; i < 24; i++) mem[i] = 8'h01;
        mem[13'h200] = 8'h9F;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_valid", 32'(bus.phoneme_valid), 0);
        check("reset_addr", 32'(bus.rom_addr), 0);
        check("reset_done", 32'(bus.done), 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        run_utt(13'h100, 0, 0, 0);
        run_utt(13'h1FFF, 0, 0, 0);
        run_utt(13'h0010, 0, 0, 0);
        run_utt(13'h100, 5, 0, 0);
        run_utt(13'h100, 0, 6, 0);
        run_utt(13'h100, 0, 0, 5);

        // start together with abort while idle must not begin
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        bus.address = 13'h100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", 32'(bus.busy), 0);
        repeat (4) @(posedge clk);
        #1;

        for (int k = 0; k < 25; k++) begin
            ra = ($urandom_range(0, 1) == 1) ? 13'(13'h1FF0 + $urandom_range(0, 15))
                                             : 13'($urandom);
            build(ra);
            len = tr.size();
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            bs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
            run_utt(ra, ab, bs, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/speech_sequencer.md
Name: speech_sequencer

Overview:
- Downstream consumer of speech_planner's 13-bit utterance address.
- On start, walks the phoneme ROM from that address one byte per phoneme.
- Presents each phoneme code for a ROM-encoded duration, then fetches the next one.
- Stops at the end-of-utterance flag, at MAX_LEN phonemes, or on abort. Feeds the sound generator.

Parameters:
- TICK_CYCLES, 256, clock cycles per duration unit; must be ≥1.
- MAX_LEN, 64, maximum phonemes per utterance (runaway guard); must be ≥1.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  request to speak the utterance at address; sampled only in IDLE
- abort  in  1  synchronous cancel of the utterance in progress
- address  in  13  utterance start address from speech_planner
- rom_data  in  8  ROM byte; valid the cycle after rom_addr changes (1-cycle synchronous ROM)
- rom_addr  out  13  ROM read address
- phoneme  out  5  current phoneme code; 0 = silence
- phoneme_valid  out  1  high while a non-silence phoneme is playing
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (nrst low, asynchronous) sets all registers to zero:
  - state=IDLE, rom_addr=0, phoneme=0, phoneme_valid=0, busy=0, done=0, duration counter=0, phoneme count=0.
- ROM byte format:
  - bit7 = last (end of utterance)
  - bits6:5 = dur
  - bits4:0 = phoneme code
  - Play time is (dur+1)*TICK_CYCLES cycles.
- IDLE:
  - done=0, busy=0.
  - If start=1 and abort=0: rom_addr<=address, count<=0, go to FETCH.
- FETCH (1 cycle): waits out the ROM latency; phoneme_valid=0. Next state is LATCH.
- LATCH (1 cycle):
  - Capture rom_data into phoneme, last and dur.
  - Load counter = (dur+1)*TICK_CYCLES-1.
  - count<=count+1.
  - Go to PLAY.
- PLAY:
  - phoneme_valid = (phoneme≠0). Counter decrements each cycle.
  - When counter=0 and (last=1 or count=MAX_LEN): go to DONE.
  - When counter=0 otherwise: rom_addr<=rom_addr+1, go to FETCH.
- DONE (1 cycle): done=1, busy=1, phoneme_valid=0, then IDLE. phoneme keeps its last value.
- Timing:
  - First phoneme is visible 2 cycles after start is accepted.
  - Consecutive phonemes are separated by a 2-cycle gap (FETCH+LATCH) with phoneme_valid=0.
- Address arithmetic: rom_addr increments modulo 2^13, so 0x1FFF wraps to 0x0000.
- Counter width: ceil(log2(4*TICK_CYCLES)) bits.
- abort:
  - From any non-IDLE state, abort=1 forces IDLE on the next edge.
  - On that edge phoneme_valid<=0 and phoneme<=0; done is not pulsed.
  - abort has priority over start and over all other transitions.
- start while busy is ignored, not queued. address is sampled only at acceptance, so later changes do not affect the running utterance.
- start and abort both high in IDLE: stay in IDLE.
- nrst asserted mid-utterance returns all outputs to their reset values immediately.

Test Plan:
All scenarios use TICK_CYCLES=4 and MAX_LEN=4.
- Reset check: drive nrst low mid-PLAY → phoneme_valid, busy and rom_addr are 0 immediately, with no clock edge needed.
- Single utterance:
  - Stimulus: ROM[0x100]=0x25 (dur1, ph5), ROM[0x101]=0x83 (last, dur0, ph3); start=1 with address=0x100 for one cycle.
  - Required: ph5 with valid high for 8 cycles, then a 2-cycle gap, then ph3 for 4 cycles, then done for 1 cycle.
  - Required: busy high from the cycle after start through the done cycle.
- Silence and wrap:
  - Stimulus: ROM[0x1FFF]=0x00, ROM[0x0000]=0x87; start with address=0x1FFF.
  - Required: 4 cycles with phoneme=0 and valid=0, then rom_addr=0x0000, then ph7 valid for 4 cycles, then done.
- MAX_LEN guard:
  - Stimulus: ROM[0x10..0x17] all 0x01 (last flag never set).
  - Required: exactly 4 phonemes, done pulses, final rom_addr=0x13.
- Abort:
  - Stimulus: abort during PLAY of the first phoneme.
  - Required: next cycle IDLE, busy=0, phoneme=0; no done pulse in the following 10 cycles.
- start while busy: pulse start with address=0x200 during PLAY → ignored; the utterance finishes from its original address and rom_addr never equals 0x200.
